// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch side of the CPU: reset constants,
// ROM geometry, the IF/ID register layout and the IF/ID update control.
package cpu_defs_pkg;

  localparam int          ADDR_W     = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_WORDS = 256;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       instr;
  } ifid_t;

  // What the IF/ID register does on the coming edge.
  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_HOLD   = 2'd2
  } ifid_ctrl_e;

  // Word-align a byte address by clearing its two low bits.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority selector for the next PC and the IF/ID update action.
// Priority: redirect > flush > stall > normal sequential fetch.
module pc_next_sel
  import cpu_defs_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output ifid_ctrl_e        ctrl_o
);

  logic [ADDR_W-1:0] pc_inc;

  // Sequential successor; wraps modulo 2^32.
  assign pc_inc = pc_i + 32'd4;

  // Resolve the highest-priority request into next PC and IF/ID action.
  always_comb begin
    next_pc_o = pc_inc;
    ctrl_o    = IFID_LOAD;
    if (redirect_valid_i) begin
      // A redirect wins over stall and flush: the stalled instruction is
      // on the wrong path anyway.
      next_pc_o = word_align(redirect_pc_i);
      ctrl_o    = IFID_BUBBLE;
    end else if (flush_i) begin
      next_pc_o = stall_i ? pc_i : pc_inc;
      ctrl_o    = IFID_BUBBLE;
    end else if (stall_i) begin
      next_pc_o = pc_i;
      ctrl_o    = IFID_HOLD;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the combinational ROM,
// captures the returned word into IF/ID, and tracks debug status.
//
// Interface contract: imem_addr_o is the current PC and the ROM answers in
// the same cycle on imem_instr_i. ifid_valid_o qualifies the IF/ID outputs:
// when low the register holds a bubble (NOP_WORD) and decode must ignore it.
// There is no backpressure other than stall_i, which freezes PC and IF/ID.
module instruction_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P   = RESET_PC,
  parameter int          IMEM_WORDS_P = IMEM_WORDS,
  parameter logic [31:0] NOP_WORD_P   = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  output logic              ifid_valid_o,
  output logic [ADDR_W-1:0] ifid_pc_o,
  output logic [ADDR_W-1:0] ifid_pc_plus4_o,
  output logic [31:0]       ifid_instr_o,
  output logic              misalign_o,
  output logic              range_err_o,
  output logic [31:0]       fetch_count_o
);

  localparam logic [ADDR_W-1:0] IMEM_LIMIT = 32'(IMEM_WORDS_P * 4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic [31:0]       count_q, count_d;
  logic              misalign_q, misalign_d;
  logic              range_err_q, range_err_d;
  ifid_ctrl_e        ifid_ctrl;

  pc_next_sel u_pc_next_sel (
    .pc_i             (pc_q),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .next_pc_o        (pc_d),
    .ctrl_o           (ifid_ctrl)
  );

  // Next IF/ID contents, retired-fetch counter and status flags.
  always_comb begin
    ifid_d      = ifid_q;
    count_d     = count_q;
    misalign_d  = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
    // Sticky: flags the cycle the PC first lands outside the ROM.
    range_err_d = range_err_q || (pc_d >= IMEM_LIMIT);
    case (ifid_ctrl)
      IFID_LOAD: begin
        ifid_d.valid    = 1'b1;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = pc_q + 32'd4;
        ifid_d.instr    = imem_instr_i;
        if (count_q != 32'hFFFF_FFFF) begin
          count_d = count_q + 32'd1;
        end
      end
      IFID_BUBBLE: begin
        // PC fields are left as they were; only the payload is killed.
        ifid_d.valid = 1'b0;
        ifid_d.instr = NOP_WORD_P;
      end
      default: begin
        ifid_d = ifid_q;
      end
    endcase
  end

  // PC, IF/ID and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC_P;
      ifid_q      <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_WORD_P};
      count_q     <= '0;
      misalign_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
      range_err_q <= range_err_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign ifid_valid_o    = ifid_q.valid;
  assign ifid_pc_o       = ifid_q.pc;
  assign ifid_pc_plus4_o = ifid_q.pc_plus4;
  assign ifid_instr_o    = ifid_q.instr;
  assign misalign_o      = misalign_q;
  assign range_err_o     = range_err_q;
  assign fetch_count_o   = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random
// stall/flush/redirect traffic, checked against a cycle-level model.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        mis;
    logic        rerr;
    logic [31:0] cnt;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);
  localparam logic [31:0] ROM_BYTES = 32'd1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall, flush, redir;
  logic [31:0] redir_pc;
  logic [31:0] imem_addr, imem_instr;
  logic        ifid_valid, misalign, range_err;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr, fetch_count;

  logic [31:0] rom [256];

  // Combinational ROM: out-of-range addresses read as 0.
  assign imem_instr = (imem_addr < ROM_BYTES) ? rom[imem_addr[9:2]] : 32'h0;

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .ifid_valid_o     (ifid_valid),
    .ifid_pc_o        (ifid_pc),
    .ifid_pc_plus4_o  (ifid_pc4),
    .ifid_instr_o     (ifid_instr),
    .misalign_o       (misalign),
    .range_err_o      (range_err),
    .fetch_count_o    (fetch_count)
  );

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic obs_t sample_dut();
    obs_t o;
    o.addr  = imem_addr;
    o.valid = ifid_valid;
    o.pc    = ifid_pc;
    o.pc4   = ifid_pc4;
    o.instr = ifid_instr;
    o.mis   = misalign;
    o.rerr  = range_err;
    o.cnt   = fetch_count;
    return o;
  endfunction

  task automatic compare_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".imem_addr"}, a.addr, e.addr);
    chk({tag, ".ifid_valid"}, {31'b0, a.valid}, {31'b0, e.valid});
    chk({tag, ".ifid_pc"}, a.pc, e.pc);
    chk({tag, ".ifid_pc_plus4"}, a.pc4, e.pc4);
    chk({tag, ".ifid_instr"}, a.instr, e.instr);
    chk({tag, ".misalign"}, {31'b0, a.mis}, {31'b0, e.mis});
    chk({tag, ".range_err"}, {31'b0, a.rerr}, {31'b0, e.rerr});
    chk({tag, ".fetch_count"}, a.cnt, e.cnt);
  endtask

  // ---------------- reference model ----------------
  // Architectural view: a PC, a one-entry decode latch, a counter, flags.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_valid, m_mis, m_rerr;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a / 4;
    return (a < ROM_BYTES) ? rom[idx[7:0]] : 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    m_instr = 32'h0; m_cnt = 32'h0; m_mis = 1'b0; m_rerr = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    m_mis = r && (rpc % 4 != 0);
    if (r) begin
      m_pc = rpc - (rpc % 4);
      m_valid = 1'b0; m_instr = 32'h0;
    end else if (f) begin
      m_valid = 1'b0; m_instr = 32'h0;
      if (!s) m_pc = m_pc + 4;
    end else if (!s) begin
      m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = rom_word(m_pc);
      m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    if (m_pc >= ROM_BYTES) m_rerr = 1'b1;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.addr = m_pc; o.valid = m_valid; o.pc = m_ipc; o.pc4 = m_ipc4;
    o.instr = m_instr; o.mis = m_mis; o.rerr = m_rerr; o.cnt = m_cnt;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock of stimulus; expected post-edge state goes to the scoreboard.
  task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    reset_n = 1'b1;
    stall = s; flush = f; redir = r; redir_pc = rpc;
    model_edge(s, f, r, rpc);
    exp_q.push_back(model_obs());
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    stall = 1'b0; flush = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    model_reset();
    exp_q.push_back(model_obs());
  endtask

  // Drop reset between edges and check outputs react without a clock.
  task automatic async_reset();
    obs_t e;
    @(negedge clk);
    #2 reset_n = 1'b0;
    stall = 1'b0; flush = 1'b0; redir = 1'b0;
    #1;
    model_reset();
    e = model_obs();
    compare_obs("async_reset", sample_dut(), e);
    exp_q.push_back(e);
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic s, f, r;
      logic [31:0] t;
      s = ($urandom_range(0, 99) < 20);
      f = ($urandom_range(0, 99) < 10);
      r = ($urandom_range(0, 99) < 10);
      t = $urandom_range(0, 32'h47F);
      step(s, f, r, t);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      compare_obs("cycle", sample_dut(), e);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: test did not complete, pending=%0d", exp_q.size());
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    stall = 1'b0; flush = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h2410_0000;
    rom[1] = 32'h3c01_4000;
    model_reset();

    // Reset held across clock edges.
    hold_reset();
    hold_reset();

    // Free run: words 0 and 1, then on to pc=0x10.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Stall two cycles at pc=0x10, then latch word 4.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // Flush with and without stall.
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    // Jump overriding stall and flush.
    step(1, 1, 1, 32'h7C);
    step(0, 0, 0, 0);
    // Misaligned redirect: single-cycle pulse.
    step(0, 0, 1, 32'h7E);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Self-loop: bubbles, no count change.
    step(0, 0, 1, 32'h84);
    step(0, 0, 1, 32'h84);
    step(0, 0, 1, 32'h84);
    step(0, 0, 0, 0);

    // Random traffic within and slightly beyond the ROM.
    random_steps(200);

    // Async reset clears everything including range_err.
    async_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // ROM boundary: 0x3F8, 0x3FC, then 0x400 raises range_err.
    step(0, 0, 1, 32'h3F8);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // 32-bit wrap of the PC.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    async_reset();
    random_steps(200);

    // Let the monitor drain outstanding expectations.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction ROM. Owns the program counter, drives the ROM byte address, and captures the returned word into the IF/ID pipeline register.
- Applies stall, flush and branch/jump redirects from later stages.
- Keeps a saturating retired-fetch counter for the debug/LED path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 256, ROM depth in words (ROM decodes Address[9:2])
NOP_WORD, 32'h0000_0000, instruction inserted on bubble/flush

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall_i  in  1  hold PC and IF/ID (load-use hazard)
flush_i  in  1  replace IF/ID with bubble
redirect_valid_i  in  1  take redirect_pc_i as next PC
redirect_pc_i  in  32  branch/jump/jr target
imem_addr_o  out  32  byte address to ROM
imem_instr_i  in  32  ROM data, valid same cycle as imem_addr_o
ifid_valid_o  out  1  IF/ID holds a real instruction
ifid_pc_o  out  32  PC of IF/ID instruction
ifid_pc_plus4_o  out  32  ifid_pc_o + 4, for link/branch
ifid_instr_o  out  32  IF/ID instruction
misalign_o  out  1  one-cycle pulse: redirect target had nonzero [1:0]
range_err_o  out  1  sticky: PC reached or passed IMEM_WORDS*4
fetch_count_o  out  32  number of valid instructions latched into IF/ID

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC.
  - ifid_valid_o = 0; ifid_pc_o = 0; ifid_pc_plus4_o = 0; ifid_instr_o = NOP_WORD.
  - misalign_o = 0; range_err_o = 0; fetch_count_o = 0.
- ROM address: imem_addr_o = pc, purely combinational. The ROM word is sampled on the same rising edge; fetch latency to IF/ID is 1 cycle.
- Per-edge priority, highest first:
  1. redirect_valid_i:
     - pc <= {redirect_pc_i[31:2], 2'b00}.
     - IF/ID <= bubble (valid = 0, instr = NOP_WORD, pc fields unchanged).
     - Overrides stall_i and flush_i.
     - misalign_o = 1 next cycle if redirect_pc_i[1:0] != 0.
  2. flush_i:
     - IF/ID <= bubble.
     - pc <= pc + 4 if !stall_i, otherwise pc is held.
  3. stall_i: pc and all IF/ID fields hold their values.
  4. Normal:
     - pc <= pc + 4.
     - IF/ID <= {valid = 1, pc, pc + 4, imem_instr_i}.
     - fetch_count_o increments.
- fetch_count_o:
  - Increments only in case 4.
  - Saturates at 32'hFFFF_FFFF.
- PC arithmetic:
  - 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.
  - pc[1:0] is always 00.
- Range check:
  - range_err_o sets when pc >= IMEM_WORDS*4 and stays set until reset.
  - Fetch continues; the ROM returns its default 0 (nop).
- Self-loop (redirect target equals current pc): legal. Each cycle produces a bubble; the counter does not increment.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk. The first fetch after release is from RESET_PC.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - RESET_PC, NOP_WORD, IMEM_WORDS;
  - a packed struct ifid_t {valid, pc, pc_plus4, instr};
  - the 32-bit address width constant.
- One natural sub-module, pc_next_sel: a combinational priority mux producing next_pc and the bubble/load/hold control from redirect/flush/stall.
- The PC register, IF/ID register and counter live in the top module.

Test Plan:
- Reset check: hold reset_n=0 across clock edges -> imem_addr_o=0, ifid_valid_o=0, ifid_instr_o=0, fetch_count_o=0.
- Free run from reset with ROM word 0 = 32'h24100000 and word 1 = 32'h3c014000:
  - after edge 1: ifid_instr_o=24100000, ifid_pc_o=0, ifid_pc_plus4_o=4, imem_addr_o=4;
  - after edge 2: ifid_instr_o=3c014000, fetch_count_o=2.
- Stall: assert stall_i for 2 cycles while pc=0x10 -> imem_addr_o stays 0x10; IF/ID unchanged; count unchanged. After release, next edge latches word 4.
- Jump: redirect_valid_i=1, redirect_pc_i=0x7C, together with stall_i=1 and flush_i=1 -> next imem_addr_o=0x7C, ifid_valid_o=0; following edge gives ifid_pc_o=0x7C.
- Misaligned redirect: redirect_pc_i=0x7E -> pc=0x7C; misalign_o high for exactly one cycle.
- Boundary and reset:
  - Run pc to 0x3FC then +4 -> range_err_o=1 and ifid_instr_o=0 on the next latch.
  - Drop reset_n between clock edges -> outputs reset asynchronously; range_err_o clears.
